// File: rtl/ffe_adapt_sequencer_if.sv
// Purpose : bundles the sequencer's command, config, estimator and status signals.
// Latency : n/a (wiring only).
// Backpressure: none; the command port is a fixed-length exec_inst pulse.
//
// Optional macro FFE_SEQ_STATUS_EN adds seq_state/peak_pos/peak_mag readback.
// Modports: master = config bank / estimator side (drives start, abort, config
// and ffe_est); slave = sequencer (drives exec_inst, inst, gain, status).
interface ffe_adapt_sequencer_if #(
    parameter int est_depth          = 10,
    parameter int ffe_bitwidth       = 10,
    parameter int adapt_bitwidth     = 14,
    parameter int cnt_bitwidth       = 16,
    parameter int max_shift_bitwidth = 3
);
    localparam int GAIN_W = $clog2(adapt_bitwidth);
    localparam int POS_W  = $clog2(est_depth);

    // control and config
    logic                           start;
    logic                           abort;
    logic [GAIN_W-1:0]              init_gain;
    logic [GAIN_W-1:0]              final_gain;
    logic [cnt_bitwidth-1:0]        gear_cycles;
    logic [POS_W-1:0]               cursor_pos;
    logic [max_shift_bitwidth-1:0]  max_shifts;

    // estimator taps
    logic signed [ffe_bitwidth-1:0] ffe_est [est_depth];

    // estimator command port
    logic                           exec_inst;
    logic [2:0]                     inst;
    logic [GAIN_W-1:0]              gain;

    // status
    logic                           busy;
    logic                           done;
    logic                           centered;
    logic [max_shift_bitwidth-1:0]  shifts_used;

`ifdef FFE_SEQ_STATUS_EN
    logic [2:0]                     seq_state;
    logic [POS_W-1:0]               peak_pos;
    logic [ffe_bitwidth:0]          peak_mag;

    modport master (
        output start, abort, init_gain, final_gain, gear_cycles, cursor_pos,
               max_shifts, ffe_est,
        input  exec_inst, inst, gain, busy, done, centered, shifts_used,
               seq_state, peak_pos, peak_mag
    );
    modport slave (
        input  start, abort, init_gain, final_gain, gear_cycles, cursor_pos,
               max_shifts, ffe_est,
        output exec_inst, inst, gain, busy, done, centered, shifts_used,
               seq_state, peak_pos, peak_mag
    );
`else
    modport master (
        output start, abort, init_gain, final_gain, gear_cycles, cursor_pos,
               max_shifts, ffe_est,
        input  exec_inst, inst, gain, busy, done, centered, shifts_used
    );
    modport slave (
        input  start, abort, init_gain, final_gain, gear_cycles, cursor_pos,
               max_shifts, ffe_est,
        output exec_inst, inst, gain, busy, done, centered, shifts_used
    );
`endif
endinterface

// File: rtl/ffe_adapt_sequencer.sv
// Purpose : FFE estimator controller: load taps, LMS gear-shift adaptation, peak scan, cursor centering.
// Latency : LOAD/SHIFT cmd_hold+2 cycles, ADAPT gear_cycles per gear, GEAR 1, SCAN est_depth cycles.
// Backpressure: none; start is ignored while busy, abort forces IDLE on the next cycle.
//
// Ports: clk, rst_n (async active-low) plus interface 'bus' (slave modport):
//   in  start, abort, init_gain, final_gain, gear_cycles, cursor_pos, max_shifts, ffe_est
//   out exec_inst, inst, gain, busy, done, centered, shifts_used
// Optional macro FFE_SEQ_STATUS_EN: adds seq_state, peak_pos, peak_mag readback.
module ffe_adapt_sequencer #(
    parameter int est_depth          = 10,
    parameter int ffe_bitwidth       = 10,
    parameter int adapt_bitwidth     = 14,
    parameter int cnt_bitwidth       = 16,
    parameter int max_shift_bitwidth = 3,
    parameter int cmd_hold           = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ffe_adapt_sequencer_if.slave bus
);
    localparam int GAIN_W = $clog2(adapt_bitwidth);
    localparam int POS_W  = $clog2(est_depth);
    localparam int MAG_W  = ffe_bitwidth + 1;
    localparam int CMD_W  = $clog2(cmd_hold + 2) + 1;

    localparam logic [2:0] INST_IDLE = 3'b000;
    localparam logic [2:0] INST_LOAD = 3'b100;
    localparam logic [2:0] INST_SHL  = 3'b011;
    localparam logic [2:0] INST_SHR  = 3'b010;

    // Command phase milestones: exec high for cycles 0..cmd_hold-1, inst held
    // one more cycle, one idle-inst cycle, then leave the state.
    localparam logic [CMD_W-1:0] CMD_LAST_EXEC = CMD_W'(cmd_hold - 1);
    localparam logic [CMD_W-1:0] CMD_INST_OFF  = CMD_W'(cmd_hold);
    localparam logic [CMD_W-1:0] CMD_EXIT      = CMD_W'(cmd_hold + 1);
    localparam logic [POS_W-1:0] LAST_IDX      = POS_W'(est_depth - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ADAPT = 3'd2,
        S_GEAR  = 3'd3,
        S_SCAN  = 3'd4,
        S_SHIFT = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t                          r_state;

    // registered outputs
    logic                            r_exec_inst;
    logic [2:0]                      r_inst;
    logic [GAIN_W-1:0]               r_gain;
    logic                            r_busy;
    logic                            r_done;
    logic                            r_centered;
    logic [max_shift_bitwidth-1:0]   r_shifts_used;

    // config captured at the accepted start
    logic [GAIN_W-1:0]               r_init_gain;
    logic [GAIN_W-1:0]               r_final_gain;
    logic [cnt_bitwidth-1:0]         r_gear_cycles;
    logic [POS_W-1:0]                r_cursor_pos;
    logic [max_shift_bitwidth-1:0]   r_max_shifts;

    // sequencing counters and scan state
    logic [cnt_bitwidth-1:0]         r_cnt;
    logic [CMD_W-1:0]                r_cmd_cnt;
    logic [POS_W-1:0]                r_idx;
    logic [POS_W-1:0]                r_peak_idx;
    logic [MAG_W-1:0]                r_peak_mag;

`ifdef FFE_SEQ_STATUS_EN
    logic [POS_W-1:0]                r_stat_peak_pos;
    logic [MAG_W-1:0]                r_stat_peak_mag;
`endif

    // scan datapath
    logic signed [ffe_bitwidth-1:0]  w_tap;
    logic [MAG_W-1:0]                w_tap_ext;
    logic [MAG_W-1:0]                w_tap_abs;
    logic                            w_new_max;
    logic [POS_W-1:0]                w_peak_idx;
    logic [MAG_W-1:0]                w_peak_mag;

    // config normalisation
    logic [GAIN_W-1:0]               w_init_gain;
    logic [cnt_bitwidth-1:0]         w_gear_cycles;

    assign w_tap     = bus.ffe_est[r_idx];
    // One extra bit so that |most-negative| is representable.
    assign w_tap_ext = {w_tap[ffe_bitwidth-1], w_tap};
    assign w_tap_abs = w_tap[ffe_bitwidth-1] ? (~w_tap_ext + MAG_W'(1)) : w_tap_ext;
    // Strict compare keeps the lowest index on ties.
    assign w_new_max  = (w_tap_abs > r_peak_mag);
    assign w_peak_idx = w_new_max ? r_idx : r_peak_idx;
    assign w_peak_mag = w_new_max ? w_tap_abs : r_peak_mag;

    // The schedule only ever decays, so a start gain below the floor is raised to it.
    assign w_init_gain   = (bus.init_gain < bus.final_gain) ? bus.final_gain : bus.init_gain;
    assign w_gear_cycles = (bus.gear_cycles == '0) ? cnt_bitwidth'(1) : bus.gear_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_exec_inst     <= 1'b0;
            r_inst          <= INST_IDLE;
            r_gain          <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_centered      <= 1'b0;
            r_shifts_used   <= '0;
            r_init_gain     <= '0;
            r_final_gain    <= '0;
            r_gear_cycles   <= '0;
            r_cursor_pos    <= '0;
            r_max_shifts    <= '0;
            r_cnt           <= '0;
            r_cmd_cnt       <= '0;
            r_idx           <= '0;
            r_peak_idx      <= '0;
            r_peak_mag      <= '0;
`ifdef FFE_SEQ_STATUS_EN
            r_stat_peak_pos <= '0;
            r_stat_peak_mag <= '0;
`endif
        end else if (bus.abort) begin
            // Abort wins over start; gain deliberately keeps its last value.
            r_state       <= S_IDLE;
            r_exec_inst   <= 1'b0;
            r_inst        <= INST_IDLE;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_centered    <= 1'b0;
            r_shifts_used <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_init_gain   <= w_init_gain;
                        r_final_gain  <= bus.final_gain;
                        r_gear_cycles <= w_gear_cycles;
                        r_cursor_pos  <= bus.cursor_pos;
                        r_max_shifts  <= bus.max_shifts;
                        r_state       <= S_LOAD;
                        r_exec_inst   <= 1'b1;
                        r_inst        <= INST_LOAD;
                        r_cmd_cnt     <= '0;
                        r_busy        <= 1'b1;
                        r_done        <= 1'b0;
                        r_centered    <= 1'b0;
                        r_shifts_used <= '0;
                    end
                end

                S_LOAD, S_SHIFT: begin
                    r_cmd_cnt <= r_cmd_cnt + CMD_W'(1);
                    if (r_cmd_cnt == CMD_LAST_EXEC) begin
                        r_exec_inst <= 1'b0;
                    end
                    if (r_cmd_cnt == CMD_INST_OFF) begin
                        r_inst <= INST_IDLE;
                    end
                    if (r_cmd_cnt == CMD_EXIT) begin
                        r_state <= S_ADAPT;
                        r_cnt   <= '0;
                        // After a shift the taps only need a fine re-converge.
                        r_gain  <= (r_state == S_LOAD) ? r_init_gain : r_final_gain;
                    end
                end

                S_ADAPT: begin
                    if (r_cnt == r_gear_cycles - cnt_bitwidth'(1)) begin
                        r_state <= S_GEAR;
                    end else begin
                        r_cnt <= r_cnt + cnt_bitwidth'(1);
                    end
                end

                S_GEAR: begin
                    if (r_gain > r_final_gain) begin
                        r_gain  <= r_gain - GAIN_W'(1);
                        r_cnt   <= '0;
                        r_state <= S_ADAPT;
                    end else begin
                        r_idx      <= '0;
                        r_peak_idx <= '0;
                        r_peak_mag <= '0;
                        r_state    <= S_SCAN;
                    end
                end

                S_SCAN: begin
                    r_peak_idx <= w_peak_idx;
                    r_peak_mag <= w_peak_mag;
                    if (r_idx != LAST_IDX) begin
                        r_idx <= r_idx + POS_W'(1);
                    end else begin
`ifdef FFE_SEQ_STATUS_EN
                        r_stat_peak_pos <= w_peak_idx;
                        r_stat_peak_mag <= w_peak_mag;
`endif
                        if (w_peak_idx == r_cursor_pos) begin
                            r_state    <= S_DONE;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_centered <= 1'b1;
                        end else if (r_shifts_used == r_max_shifts) begin
                            r_state    <= S_DONE;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_centered <= 1'b0;
                        end else begin
                            // Peak left of target -> move taps toward higher index.
                            r_state       <= S_SHIFT;
                            r_exec_inst   <= 1'b1;
                            r_inst        <= (w_peak_idx < r_cursor_pos) ? INST_SHR : INST_SHL;
                            r_cmd_cnt     <= '0;
                            r_shifts_used <= r_shifts_used + max_shift_bitwidth'(1);
                        end
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_exec_inst <= 1'b0;
                    r_inst      <= INST_IDLE;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.exec_inst   = r_exec_inst;
    assign bus.inst        = r_inst;
    assign bus.gain        = r_gain;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.centered    = r_centered;
    assign bus.shifts_used = r_shifts_used;

`ifdef FFE_SEQ_STATUS_EN
    assign bus.seq_state   = r_state;
    assign bus.peak_pos    = r_stat_peak_pos;
    assign bus.peak_mag    = r_stat_peak_mag;
`endif
endmodule

// File: tb/tb_ffe_adapt_sequencer.sv
// Purpose : directed + randomized bench for ffe_adapt_sequencer with a trace-level reference model.
// Latency : n/a.
// Backpressure: n/a; the bench emulates estimator tap shifts on each shift command.
module tb_ffe_adapt_sequencer;
    localparam int DEPTH = 10;
    localparam int FBW   = 10;

    typedef struct packed {
        logic       exec;
        logic [2:0] inst;
        logic [3:0] gain;
        logic       busy;
        logic       done;
        logic       cen;
        logic [2:0] su;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ffe_adapt_sequencer_if bus ();
    ffe_adapt_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];
    int   taps[DEPTH];
    int   last_gain = 0;
    int   m_su, m_cen;
    int   n_shr, n_shl, n_exec, n_ld;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.exec = bus.exec_inst; o.inst = bus.inst; o.gain = bus.gain;
        o.busy = bus.busy; o.done = bus.done; o.cen = bus.centered; o.su = bus.shifts_used;
        return o;
    endfunction

    function automatic void push(int n, bit ex, logic [2:0] ins, int g, bit bsy, bit dn, bit cn, int su);
        obs_t o;
        o.exec = ex; o.inst = ins; o.gain = 4'(g); o.busy = bsy; o.done = dn; o.cen = cn; o.su = 3'(su);
        for (int i = 0; i < n; i++) exp_q.push_back(o);
    endfunction

    // A command: exec for 3 cycles, inst one cycle longer, one idle cycle.
    function automatic void push_cmd(logic [2:0] code, int g, int su);
        push(3, 1, code, g, 1, 0, 0, su);
        push(1, 0, code, g, 1, 0, 0, su);
        push(1, 0, 3'b000, g, 1, 0, 0, su);
    endfunction

    // Expected per-cycle outputs of one whole sequence, from the behavioural rules.
    function automatic void build_model(int ig, int fg, int gc, int cur, int ms);
        int t[DEPTH];
        int g0, n, su, peak, best, a;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) t[i] = taps[i];
        g0 = (ig < fg) ? fg : ig;
        n  = (gc == 0) ? 1 : gc;
        su = 0;
        push_cmd(3'b100, last_gain, 0);
        for (int g = g0; g >= fg; g--) push(n + 1, 0, 3'b000, g, 1, 0, 0, 0);
        for (int iter = 0; iter < 16; iter++) begin
            push(DEPTH, 0, 3'b000, fg, 1, 0, 0, su);
            peak = 0; best = -1;
            for (int i = 0; i < DEPTH; i++) begin
                a = (t[i] < 0) ? -t[i] : t[i];
                if (a > best) begin best = a; peak = i; end
            end
            if (peak == cur) begin
                push(4, 0, 3'b000, fg, 0, 1, 1, su); m_cen = 1; break;
            end
            if (su == ms) begin
                push(4, 0, 3'b000, fg, 0, 1, 0, su); m_cen = 0; break;
            end
            su++;
            if (peak < cur) begin
                for (int i = DEPTH - 1; i > 0; i--) t[i] = t[i-1];
                t[0] = 0;
                push_cmd(3'b010, fg, su);
            end else begin
                for (int i = 0; i < DEPTH - 1; i++) t[i] = t[i+1];
                t[DEPTH-1] = 0;
                push_cmd(3'b011, fg, su);
            end
            push(n + 1, 0, 3'b000, fg, 1, 0, 0, su);
        end
        m_su = su;
        last_gain = fg;
    endfunction

    task automatic apply_cfg(int ig, int fg, int gc, int cur, int ms);
        bus.init_gain   = 4'(ig);
        bus.final_gain  = 4'(fg);
        bus.gear_cycles = 16'(gc);
        bus.cursor_pos  = 4'(cur);
        bus.max_shifts  = 3'(ms);
        for (int i = 0; i < DEPTH; i++) bus.ffe_est[i] = FBW'(taps[i]);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs the expected trace against the DUT, emulating estimator tap shifts.
    task automatic run_trace(string tag, bit poke);
        int   bad = 0;
        int   first = -1;
        bit   prev_exec = 0;
        obs_t o, fo;
        fo = '0;
        n_shr = 0; n_shl = 0; n_exec = 0; n_ld = 0;
        for (int k = 0; k < exp_q.size(); k++) begin
            step();
            bus.start = 1'b0;
            if (k == 0) begin
                // Config changes after the accepted start must be ignored.
                bus.init_gain   = 4'($urandom);
                bus.final_gain  = 4'($urandom);
                bus.gear_cycles = 16'($urandom_range(0, 3));
                bus.cursor_pos  = 4'($urandom_range(0, 9));
                bus.max_shifts  = 3'($urandom);
            end
            o = sample();
            if (o !== exp_q[k]) begin
                bad++;
                if (first < 0) begin first = k; fo = o; end
            end
            if (o.exec) n_exec++;
            if (o.inst == 3'b100) n_ld++;
            if (o.exec && !prev_exec) begin
                if (o.inst == 3'b010) begin
                    n_shr++;
                    for (int i = DEPTH - 1; i > 0; i--) bus.ffe_est[i] = bus.ffe_est[i-1];
                    bus.ffe_est[0] = '0;
                end else if (o.inst == 3'b011) begin
                    n_shl++;
                    for (int i = 0; i < DEPTH - 1; i++) bus.ffe_est[i] = bus.ffe_est[i+1];
                    bus.ffe_est[DEPTH-1] = '0;
                end
            end
            prev_exec = o.exec;
            if (poke && k == exp_q.size() / 2 && exp_q[k].busy) bus.start = 1'b1;
        end
        if (bad != 0)
            $display("note %s first divergence at cycle %0d observed %h expected %h", tag, first, fo, exp_q[first]);
        chk({tag, " trace"}, bad, 0);
    endtask

    task automatic run_seq(string tag, int ig, int fg, int gc, int cur, int ms, bit poke);
        build_model(ig, fg, gc, cur, ms);
        apply_cfg(ig, fg, gc, cur, ms);
        bus.start = 1'b1;
        run_trace(tag, poke);
        chk({tag, " done"}, bus.done, 1);
        chk({tag, " centered"}, bus.centered, m_cen);
        chk({tag, " shifts_used"}, bus.shifts_used, m_su);
    endtask

    task automatic small_taps();
        for (int i = 0; i < DEPTH; i++) taps[i] = int'($urandom_range(0, 198)) - 99;
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, " exec_inst"}, bus.exec_inst, 0);
        chk({tag, " inst"}, bus.inst, 0);
        chk({tag, " gain"}, bus.gain, 0);
        chk({tag, " busy"}, bus.busy, 0);
        chk({tag, " done"}, bus.done, 0);
        chk({tag, " centered"}, bus.centered, 0);
        chk({tag, " shifts_used"}, bus.shifts_used, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0;
        for (int i = 0; i < DEPTH; i++) taps[i] = 0;
        apply_cfg(0, 0, 0, 0, 0);
        #12;
        chk_reset_vals("reset");
        step();
        rst_n = 1'b1;
        repeat (2) step();

        // Load + gear schedule 5,4,3 at 100 cycles each, centering disabled.
        small_taps();
        run_seq("gear", 5, 3, 100, 6, 0, 0);
        chk("gear exec cycles", n_exec, 3);
        chk("gear load inst cycles", n_ld, 4);

        // Reset asserted in the middle of LOAD.
        apply_cfg(7, 1, 10, 0, 2);
        bus.start = 1'b1;
        step(); bus.start = 1'b0;
        step();
        chk("midload exec before reset", bus.exec_inst, 1);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("midload reset");
        step(); rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (bus.exec_inst || bus.busy) cnt++;
        end
        chk("post reset idle activity", cnt, 0);
        last_gain = 0;

        // Centering right: peak at 1, target 3.
        small_taps(); taps[1] = -300;
        run_seq("center right", 4, 2, 6, 3, 4, 0);
        chk("center right shifts", bus.shifts_used, 2);
        chk("center right centered", bus.centered, 1);
        chk("center right shr cmds", n_shr, 2);
        chk("center right shl cmds", n_shl, 0);

        // Budget exhaustion: peak at 8, target 2, one shift allowed.
        small_taps(); taps[8] = 400;
        run_seq("budget", 3, 3, 4, 2, 1, 0);
        chk("budget shifts", bus.shifts_used, 1);
        chk("budget centered", bus.centered, 0);
        chk("budget shl cmds", n_shl, 1);

        // Ties with extreme codes: peak must resolve to index 2.
        small_taps(); taps[2] = -512; taps[5] = 511; taps[7] = -512;
        run_seq("tie at cursor", 2, 1, 3, 2, 3, 0);
        chk("tie at cursor shifts", bus.shifts_used, 0);
        chk("tie at cursor centered", bus.centered, 1);
        small_taps(); taps[2] = -512; taps[5] = 511; taps[7] = -512;
        run_seq("tie shift", 2, 1, 3, 3, 2, 0);
        chk("tie shift shr cmds", n_shr, 1);
        chk("tie shift centered", bus.centered, 1);

        // Abort together with start during ADAPT.
        small_taps();
        apply_cfg(6, 2, 50, 0, 0);
        bus.start = 1'b1;
        step(); bus.start = 1'b0;
        repeat (11) step();
        chk("abort pre busy", bus.busy, 1);
        chk("abort pre gain", bus.gain, 6);
        bus.abort = 1'b1; bus.start = 1'b1;
        step();
        bus.abort = 1'b0; bus.start = 1'b0;
        chk("abort busy", bus.busy, 0);
        chk("abort exec_inst", bus.exec_inst, 0);
        chk("abort inst", bus.inst, 0);
        chk("abort shifts_used", bus.shifts_used, 0);
        chk("abort gain held", bus.gain, 6);
        repeat (5) step();
        chk("abort stays idle", bus.busy, 0);

        // Abort in the middle of a command.
        apply_cfg(9, 4, 5, 1, 1);
        bus.start = 1'b1;
        step(); bus.start = 1'b0;
        step();
        chk("abort cmd exec before", bus.exec_inst, 1);
        bus.abort = 1'b1;
        step(); bus.abort = 1'b0;
        chk("abort cmd exec", bus.exec_inst, 0);
        chk("abort cmd inst", bus.inst, 0);
        last_gain = 6;

        // Fresh start after abort re-latches new config.
        small_taps(); taps[7] = 350;
        run_seq("restart", 4, 1, 7, 5, 3, 0);

        // Randomized sequences, with a start pulse injected mid-run.
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < DEPTH; i++) taps[i] = int'($urandom_range(0, 1023)) - 512;
            run_seq($sformatf("random%0d", r), int'($urandom_range(0, 13)), int'($urandom_range(0, 13)),
                    int'($urandom_range(0, 20)), int'($urandom_range(0, 9)), int'($urandom_range(0, 7)), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
